// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector default, program-counter sequencer state
// and a word-alignment helper used when latching redirect targets.
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target mux for the instruction at pc:
// jump_reg > jump > taken branch.
module pc_target_calc (
  input  logic [31:0] pc,
  input  logic        condition_met,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [15:0] imm16,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  output logic        redirect,
  output logic [31:0] target
);

  logic        [31:0] pc_plus4;
  logic signed [31:0] branch_offset;
  logic        [31:0] branch_target;

  assign pc_plus4      = pc + 32'd4;
  // Word offset: sign-extend then scale by 4, wrapping on the 32-bit add.
  assign branch_offset = $signed({{14{imm16[15]}}, imm16, 2'b00});
  assign branch_target = pc_plus4 + $unsigned(branch_offset);

  assign redirect = jump_reg | jump | condition_met;

  always_comb begin
    target = branch_target;
    if (jump_reg) begin
      target = reg_target;
    end else if (jump) begin
      target = {pc_plus4[31:28], jump_index, 2'b00};
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with a one-instruction branch delay slot: redirects are latched
// and applied when the delay-slot instruction retires; halts on HALT_ADDR or a bad target.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  input  logic        stall,
  input  logic        condition_met,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [15:0] imm16,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        active,
  output logic        addr_fault
);

  pc_state_t   state;
  logic [31:0] pending_target;
  logic [31:0] target;
  logic        redirect;
  logic        retire;

  pc_target_calc u_target_calc (
    .pc            (pc),
    .condition_met (condition_met),
    .jump          (jump),
    .jump_reg      (jump_reg),
    .imm16         (imm16),
    .jump_index    (jump_index),
    .reg_target    (reg_target),
    .redirect      (redirect),
    .target        (target)
  );

  assign retire    = advance & ~stall & (state == RUN);
  assign link_addr = pc + 32'd8;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      pending_target <= 32'h0;
      in_delay_slot  <= 1'b0;
      active         <= 1'b1;
      addr_fault     <= 1'b0;
    end else if (retire) begin
      if (in_delay_slot) begin
        // Delay slot retiring: any redirect it requests itself is dropped.
        in_delay_slot <= 1'b0;
        if (addr_fault) begin
          state  <= HALTED;
          active <= 1'b0;
        end else if (pending_target == HALT_ADDR) begin
          state  <= HALTED;
          active <= 1'b0;
          pc     <= HALT_ADDR;
        end else begin
          pc <= pending_target;
        end
      end else begin
        pc <= pc + 32'd4;
        if (redirect) begin
          pending_target <= target;
          in_delay_slot  <= 1'b1;
          if (!is_word_aligned(target)) begin
            addr_fault <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a delay-slot reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        advance;
  logic        stall;
  logic        condition_met;
  logic        jump;
  logic        jump_reg;
  logic [15:0] imm16;
  logic [25:0] jump_index;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        active;
  logic        addr_fault;

  pc_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .advance       (advance),
    .stall         (stall),
    .condition_met (condition_met),
    .jump          (jump),
    .jump_reg      (jump_reg),
    .imm16         (imm16),
    .jump_index    (jump_index),
    .reg_target    (reg_target),
    .pc            (pc),
    .link_addr     (link_addr),
    .in_delay_slot (in_delay_slot),
    .active        (active),
    .addr_fault    (addr_fault)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the architectural view of the fetch stream.
  logic [31:0] m_pc;
  logic        m_in_slot;
  logic [31:0] m_target;
  logic        m_halted;
  logic        m_fault;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check32({tag, ".pc"},    pc,                     m_pc);
    check32({tag, ".link"},  link_addr,              m_pc + 32'd8);
    check32({tag, ".slot"},  {31'd0, in_delay_slot}, {31'd0, m_in_slot});
    check32({tag, ".act"},   {31'd0, active},        {31'd0, ~m_halted});
    check32({tag, ".fault"}, {31'd0, addr_fault},    {31'd0, m_fault});
  endtask

  task automatic model_reset();
    m_pc      = 32'hBFC00000;
    m_in_slot = 1'b0;
    m_target  = 32'h0;
    m_halted  = 1'b0;
    m_fault   = 1'b0;
  endtask

  task automatic model_retire(input logic adv, input logic stl, input logic cm, input logic j,
                              input logic jr, input logic [15:0] imm, input logic [25:0] idx,
                              input logic [31:0] rt);
    logic [31:0] next_seq;
    logic [31:0] tgt;
    if (m_halted || !adv || stl) return;
    next_seq = m_pc + 32'd4;
    if (m_in_slot) begin
      m_in_slot = 1'b0;
      if (m_fault) begin
        m_halted = 1'b1;
      end else if (m_target == 32'h0) begin
        m_pc     = 32'h0;
        m_halted = 1'b1;
      end else begin
        m_pc = m_target;
      end
    end else begin
      if (jr || j || cm) begin
        if (jr)     tgt = rt;
        else if (j) tgt = {next_seq[31:28], idx, 2'b00};
        else        tgt = next_seq + 32'(4 * int'($signed(imm)));
        m_target  = tgt;
        m_in_slot = 1'b1;
        if (tgt[1:0] != 2'b00) m_fault = 1'b1;
      end
      m_pc = next_seq;
    end
  endtask

  task automatic apply(input string tag, input logic adv, input logic stl, input logic cm,
                       input logic j, input logic jr, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] rt);
    advance       = adv;
    stall         = stl;
    condition_met = cm;
    jump          = j;
    jump_reg      = jr;
    imm16         = imm;
    jump_index    = idx;
    reg_target    = rt;
    @(posedge clk);
    model_retire(adv, stl, cm, j, jr, imm, idx, rt);
    #1;
    check_model(tag);
  endtask

  task automatic step(input string tag);
    apply(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    advance = 1'b0; stall = 1'b0; condition_met = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    imm16 = 16'h0; jump_index = 26'h0; reg_target = 32'h0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_model("reset");
  endtask

  initial begin
    reset_n = 1'b1;
    do_reset();
    check32("rst_pc_const", pc, 32'hBFC00000);
    check32("rst_active_const", {31'd0, active}, 32'd1);

    // Sequential fetch after reset.
    step("seq1"); step("seq2"); step("seq3");
    check32("seq_pc_const", pc, 32'hBFC0000C);

    // Backward taken branch through its delay slot.
    step("seq4");
    apply("br", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFC, 26'h0, 32'h0);
    check32("br_slot_pc", pc, 32'hBFC00014);
    check32("br_slot_flag", {31'd0, in_delay_slot}, 32'd1);
    step("br_done");
    check32("br_target_pc", pc, 32'hBFC00004);

    // Branch requested inside the delay slot is ignored.
    apply("br2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 26'h0, 32'h0);
    apply("br_in_slot", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFF0, 26'h0, 32'h0);
    check32("br_in_slot_pc", pc, 32'hBFC00048);
    step("after_drop");
    check32("after_drop_pc", pc, 32'hBFC0004C);

    // Stall freezes a pending jump, which completes afterwards.
    apply("jmp", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000100, 32'h0);
    for (int i = 0; i < 5; i++)
      apply("stall", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0, 26'h0, 32'h4);
    check32("stall_pc", pc, 32'hBFC00050);
    check32("stall_slot", {31'd0, in_delay_slot}, 32'd1);
    step("jmp_done");
    check32("jmp_target_pc", pc, 32'hB0000400);

    // Reset asserted mid-delay-slot acts without a clock edge.
    apply("jr_pend", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h00001000);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check32("async_rst_pc", pc, 32'hBFC00000);
    check32("async_rst_slot", {31'd0, in_delay_slot}, 32'd0);
    do_reset();
    step("post_rst");
    check32("post_rst_pc", pc, 32'hBFC00004);

    // Misaligned register target: fault at latch, halt after the delay slot.
    apply("jr_bad", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h00000402);
    check32("fault_flag", {31'd0, addr_fault}, 32'd1);
    step("fault_slot");
    check32("fault_active", {31'd0, active}, 32'd0);
    check32("fault_pc", pc, 32'hBFC00008);
    step("fault_hold");

    // Jump to address 0 halts once the delay slot retires.
    do_reset();
    apply("jr_zero", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
    step("halt");
    check32("halt_pc", pc, 32'h0);
    check32("halt_active", {31'd0, active}, 32'd0);
    apply("halted_in", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 26'h3FFFFFF, 32'h100);
    check32("halted_pc", pc, 32'h0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rt;
      int sel;
      sel = int'($urandom_range(0, 99));
      rt  = $urandom & 32'hFFFFFFFC;
      if (sel < 2)      rt = 32'h0;
      else if (sel < 4) rt = rt | 32'($urandom_range(1, 3));
      apply("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0), 16'($urandom), 26'($urandom), rt);
      if (m_halted && $urandom_range(0, 2) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
